mul_add_sched: RTL and testbench
================================

# mul_add_sched

Sequential, shared implementation of the multiply-and-add function y = a·(2^(k1−k3) + 2^(k2−k3)) mod 256, serving two requesters through round-robin arbitration. It replaces two parallel combinational multiply-add instances with one shift-and-accumulate engine. It also returns a tagged result over a valid/ready response channel. It sits between two client blocks and the downstream consumer of y.

## Interface

- No parameters; all widths fixed: a/y 8 bits, k1/k2/k3 3 bits.

Ports:

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  8  multiplicand
- req0_k1, req0_k2, req0_k3  in  3 each  exponent operands
- req1_valid, req1_ready, req1_a, req1_k1, req1_k2, req1_k3: same as requester 0, for requester 1
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  1  requester index of result
- rsp_y  out  8  result

## Operation

- **Exponents:** p1 = (k1 − k3) mod 8 and p2 = (k2 − k3) mod 8, each 3-bit wrap-around. Example: k1=1, k3=3 → p1=6.
- **Result:** y = ((a << p1) + (a << p2)) mod 256. All intermediate values are truncated to 8 bits.
- **States:** IDLE, RUN, DONE.
- **IDLE:**
  - Grant goes to one valid requester; req_ready is driven combinationally for the granted requester only.
  - If both are valid, priority goes to the requester not served last. After reset, req0 has priority.
  - On valid&ready, latch a, p1, p2 and the id. Set sh=a, acc=0, cnt=0. Go to RUN.
  - If no requester is valid, stay in IDLE.
- **RUN, each cycle:**
  - acc += sh if cnt==p1; acc += sh again if cnt==p2. When p1==p2, 2·sh is added in the same cycle.
  - If cnt == max(p1,p2), go to DONE. Otherwise sh <<= 1 (8-bit, MSBs discarded) and cnt++.
- **DONE:**
  - rsp_valid=1, rsp_y=acc, rsp_id=latched id.
  - On rsp_valid&rsp_ready: go to IDLE and record the served id for round-robin.
- **Ready rule:** req0_ready and req1_ready are 0 in RUN and DONE; the engine is non-pipelined.
- **Requester obligations (not checked by the block):**
  - Operands stay stable while valid is high and ready is low.
  - valid is not withdrawn before acceptance.
- **rst during RUN or DONE:** the operation is abandoned and no response is produced.

## Timing

- **Reset values:** state=IDLE, rsp_valid=0, rsp_y=0, rsp_id=0, round-robin priority=req0. While rst is high, req0_ready=req1_ready=0.
- **Latency:** accept in cycle T → rsp_valid first high in cycle T + max(p1,p2) + 2. Range is 2..9 cycles.
- **Response hold:** rsp_valid, rsp_y and rsp_id are registered and held stable until the handshake.
- **Minimum spacing:** a response handshake in cycle R → next acceptance no earlier than cycle R+1 (IDLE). Minimum accept-to-accept spacing is max(p1,p2)+3 cycles.
- **Arbitration:** the grant decision uses only the current-cycle valids and the priority register. Both requesters holding valid continuously are served strictly alternately.

## Test plan

- **Basic:** req0: a=3, k1=5, k2=4, k3=2 (p1=3, p2=2) → rsp_y=36, rsp_id=0, rsp_valid high 5 cycles after acceptance.
- **Truncation:** req1: a=200, k1=7, k2=0, k3=0 → rsp_y=200 (the 200·128 term wraps to 0), rsp_id=1, latency 9.
- **Exponent wrap:** a=1, k1=1, k2=3, k3=3 → p1=6, p2=0, rsp_y=65.
- **Equal exponents:** a=5, k1=k2=k3=4 → rsp_y=10, latency 2.
- **Arbitration:** after reset, both valids held high with distinct operands → first grant to req0, then req1, then req0; never two ready pulses in one cycle.
- **Backpressure and reset:**
  - rsp_ready held low for 10 cycles → rsp_valid, rsp_y and rsp_id remain constant, and both req_ready stay 0.
  - rst asserted mid-RUN → the next cycle shows IDLE with rsp_valid=0, and no response is ever produced for the aborted operation.

Source files
------------

// File: rtl/mul_add_sched.sv
// Shared shift-and-accumulate engine computing y = a*(2^(k1-k3) + 2^(k2-k3)) mod 256
// for two requesters under round-robin arbitration, with a registered tagged response.
module mul_add_sched (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [2:0] req0_k1,
  input  logic [2:0] req0_k2,
  input  logic [2:0] req0_k3,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [2:0] req1_k1,
  input  logic [2:0] req1_k2,
  input  logic [2:0] req1_k3,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [7:0] rsp_y
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e     r_state;
  logic [7:0] r_sh;
  logic [7:0] r_acc;
  logic [2:0] r_cnt;
  logic [2:0] r_p1;
  logic [2:0] r_p2;
  logic [2:0] r_pmax;
  logic       r_id;
  logic       r_prio;      // 1: requester 1 wins a tie
  logic       r_rsp_valid;
  logic [7:0] r_rsp_y;
  logic       r_rsp_id;

  logic       w_idle;
  logic       w_gnt0;
  logic       w_gnt1;
  logic [7:0] w_sel_a;
  logic [2:0] w_sel_p1;
  logic [2:0] w_sel_p2;
  logic [7:0] w_add1;
  logic [7:0] w_add2;
  logic [7:0] w_acc_nxt;

  // Grant, operand select and accumulate step.
  always_comb begin
    w_idle   = (r_state == StIdle) && !rst;
    w_gnt0   = w_idle && req0_valid && (!req1_valid || !r_prio);
    w_gnt1   = w_idle && req1_valid && (!req0_valid || r_prio);
    w_sel_a  = w_gnt1 ? req1_a : req0_a;
    // 3-bit subtraction gives the mod-8 wrap for free
    w_sel_p1 = w_gnt1 ? (req1_k1 - req1_k3) : (req0_k1 - req0_k3);
    w_sel_p2 = w_gnt1 ? (req1_k2 - req1_k3) : (req0_k2 - req0_k3);
    w_add1   = (r_cnt == r_p1) ? r_sh : 8'd0;
    w_add2   = (r_cnt == r_p2) ? r_sh : 8'd0;
    w_acc_nxt = r_acc + w_add1 + w_add2;
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_y      = r_rsp_y;
  assign rsp_id     = r_rsp_id;

  // Control FSM with datapath and registered response.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StIdle;
      r_sh        <= 8'd0;
      r_acc       <= 8'd0;
      r_cnt       <= 3'd0;
      r_p1        <= 3'd0;
      r_p2        <= 3'd0;
      r_pmax      <= 3'd0;
      r_id        <= 1'b0;
      r_prio      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_y     <= 8'd0;
      r_rsp_id    <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_gnt0 || w_gnt1) begin
            r_id    <= w_gnt1;
            r_sh    <= w_sel_a;
            r_acc   <= 8'd0;
            r_cnt   <= 3'd0;
            r_p1    <= w_sel_p1;
            r_p2    <= w_sel_p2;
            r_pmax  <= (w_sel_p1 > w_sel_p2) ? w_sel_p1 : w_sel_p2;
            r_state <= StRun;
          end
        end
        StRun: begin
          if (r_cnt == r_pmax) begin
            r_rsp_valid <= 1'b1;
            r_rsp_y     <= w_acc_nxt;
            r_rsp_id    <= r_id;
            r_state     <= StDone;
          end else begin
            r_acc <= w_acc_nxt;
            r_sh  <= r_sh << 1;
            r_cnt <= r_cnt + 3'd1;
          end
        end
        StDone: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_prio      <= ~r_rsp_id;  // favour the requester not just served
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_add_sched.sv
// Directed self-checking bench for mul_add_sched: vector table plus arbitration,
// backpressure and mid-operation reset sequences.
module tb_mul_add_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_valid = 1'b0, req1_valid = 1'b0;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a = 8'd0, req1_a = 8'd0;
  logic [2:0] req0_k1 = 3'd0, req0_k2 = 3'd0, req0_k3 = 3'd0;
  logic [2:0] req1_k1 = 3'd0, req1_k2 = 3'd0, req1_k3 = 3'd0;
  logic       rsp_valid, rsp_ready = 1'b0, rsp_id;
  logic [7:0] rsp_y;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [7:0] a;
    logic [2:0] k1;
    logic [2:0] k2;
    logic [2:0] k3;
    logic [7:0] exp_y;
    int         exp_lat;
  } vec_t;

  vec_t vecs[7];

  mul_add_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_k1    (req0_k1),
    .req0_k2    (req0_k2),
    .req0_k3    (req0_k3),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_k1    (req1_k1),
    .req1_k2    (req1_k2),
    .req1_k3    (req1_k3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_y      (rsp_y)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input logic id, input logic v, input logic [7:0] a,
                         input logic [2:0] k1, input logic [2:0] k2, input logic [2:0] k3);
    if (id) begin
      req1_valid = v; req1_a = a; req1_k1 = k1; req1_k2 = k2; req1_k3 = k3;
    end else begin
      req0_valid = v; req0_a = a; req0_k1 = k1; req0_k2 = k2; req0_k3 = k3;
    end
  endtask

  // One operation from a single requester with rsp_ready held high.
  task automatic run_op(input vec_t v, input int idx);
    int  n;
    logic rdy;
    @(negedge clk);
    set_req(v.id, 1'b1, v.a, v.k1, v.k2, v.k3);
    rsp_ready = 1'b1;
    #1;
    n = 0;
    rdy = v.id ? req1_ready : req0_ready;
    while (!rdy && n < 20) begin
      @(negedge clk); #1; n++;
      rdy = v.id ? req1_ready : req0_ready;
    end
    check($sformatf("v%0d_grant", idx), {31'd0, rdy}, 32'd1);
    check($sformatf("v%0d_other_ready", idx),
          {31'd0, v.id ? req0_ready : req1_ready}, 32'd0);
    if (!rdy) begin
      set_req(v.id, 1'b0, 8'd0, 3'd0, 3'd0, 3'd0);
      return;
    end
    @(posedge clk);
    @(negedge clk);
    set_req(v.id, 1'b0, 8'd0, 3'd0, 3'd0, 3'd0);
    #1;
    n = 1;
    while (!rsp_valid && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check($sformatf("v%0d_latency", idx), n, v.exp_lat);
    check($sformatf("v%0d_y", idx), {24'd0, rsp_y}, {24'd0, v.exp_y});
    check($sformatf("v%0d_id", idx), {31'd0, rsp_id}, {31'd0, v.id});
  endtask

  initial begin
    int   ng, nr, cyc;
    logic grants[3];
    logic rids[3];
    logic [7:0] rys[3];
    logic seen;

    //            id  a     k1 k2 k3 y     lat
    vecs[0] = '{1'b0, 8'd3,   3'd5, 3'd4, 3'd2, 8'd36,  5};
    vecs[1] = '{1'b1, 8'd200, 3'd7, 3'd0, 3'd0, 8'd200, 9};
    vecs[2] = '{1'b0, 8'd1,   3'd1, 3'd3, 3'd3, 8'd65,  8};
    vecs[3] = '{1'b1, 8'd5,   3'd4, 3'd4, 3'd4, 8'd10,  2};
    vecs[4] = '{1'b0, 8'd255, 3'd0, 3'd1, 3'd0, 8'd253, 3};
    vecs[5] = '{1'b1, 8'd17,  3'd2, 3'd6, 3'd5, 8'd66,  7};
    vecs[6] = '{1'b0, 8'd171, 3'd3, 3'd3, 3'd0, 8'd176, 5};

    // Reset state: readies held low even with both requesters valid.
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check("rst_ready1", {31'd0, req1_ready}, 32'd0);
    check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rsp_y", {24'd0, rsp_y}, 32'd0);
    check("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Arbitration: both valid continuously; req0 first, then strict alternation.
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'd3, 3'd5, 3'd4, 3'd2);
    set_req(1'b1, 1'b1, 8'd5, 3'd4, 3'd4, 3'd4);
    rsp_ready = 1'b1;
    ng = 0; nr = 0; cyc = 0;
    while (nr < 3 && cyc < 80) begin
      #1;
      check("arb_one_ready", {31'd0, req0_ready & req1_ready}, 32'd0);
      if (req0_ready || req1_ready) begin
        if (ng < 3) grants[ng] = req1_ready;
        ng++;
      end
      if (rsp_valid) begin
        rids[nr] = rsp_id;
        rys[nr]  = rsp_y;
        nr++;
      end
      if (nr < 3) @(negedge clk);
      cyc++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("arb_responses", nr, 3);
    if (ng >= 3 && nr >= 3) begin
      check("arb_grant0", {31'd0, grants[0]}, 32'd0);
      check("arb_grant1", {31'd0, grants[1]}, 32'd1);
      check("arb_grant2", {31'd0, grants[2]}, 32'd0);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("arb_rsp%0d_id", i), {31'd0, rids[i]}, {31'd0, grants[i]});
        check($sformatf("arb_rsp%0d_y", i), {24'd0, rys[i]}, grants[i] ? 32'd10 : 32'd36);
      end
    end else begin
      check("arb_grants", ng, 3);
    end
    @(negedge clk);

    // Directed vector table.
    for (int i = 0; i < 7; i++) run_op(vecs[i], i);

    // Backpressure: response held stable, no grants while DONE.
    @(negedge clk);
    set_req(1'b0, 1'b1, 8'd3, 3'd5, 3'd4, 3'd2);
    rsp_ready = 1'b0;
    #1;
    check("bp_grant", {31'd0, req0_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b0, 1'b0, 8'd0, 3'd0, 3'd0, 3'd0);
    set_req(1'b1, 1'b1, 8'd9, 3'd1, 3'd2, 3'd0);
    #1;
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk); #1; cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_valid%0d", i), {31'd0, rsp_valid}, 32'd1);
      check($sformatf("bp_y%0d", i), {24'd0, rsp_y}, 32'd36);
      check($sformatf("bp_id%0d", i), {31'd0, rsp_id}, 32'd0);
      check($sformatf("bp_ready%0d", i), {30'd0, req1_ready, req0_ready}, 32'd0);
      @(negedge clk); #1;
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset in the middle of RUN: operation abandoned, no response.
    @(negedge clk);
    set_req(1'b1, 1'b1, 8'd200, 3'd7, 3'd0, 3'd0);
    #1;
    check("mid_grant", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    set_req(1'b1, 1'b0, 8'd0, 3'd0, 3'd0, 3'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    set_req(1'b0, 1'b1, 8'd1, 3'd1, 3'd1, 3'd1);
    #1;
    check("mid_rst_ready0", {31'd0, req0_ready}, 32'd0);
    @(negedge clk);
    #1;
    check("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("mid_rst_ready0b", {31'd0, req0_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_idle_ready0", {31'd0, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk); #1;
      if (rsp_valid) seen = 1'b1;
    end
    check("mid_no_rsp", {31'd0, seen}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
